inst_mem_responder: RTL



---
 rtl/inst_mem_responder_pkg.sv | 20 ++
 rtl/inst_mem_responder_if.sv | 28 ++
 rtl/inst_byte_assembler.sv | 28 ++
 rtl/inst_mem_responder.sv | 85 ++++++++
 4 files changed

// File: rtl/inst_mem_responder_pkg.sv
// Shared definitions for the instruction-fetch responder: bus types, fill FSM
// encoding and the default backing-memory address width.
package inst_mem_responder_pkg;

  localparam int unsigned INST_ADDR_W    = 32;
  localparam int unsigned INST_W         = 32;
  localparam int unsigned MEM_AW_DEFAULT = 17;

  typedef logic [INST_ADDR_W-1:0] inst_addr_bus_t;
  typedef logic [INST_W-1:0]      inst_bus_t;
  typedef logic [INST_ADDR_W-3:0] buf_tag_t;

  localparam inst_bus_t ZERO_WORD = '0;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_BUSY = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/inst_mem_responder_if.sv
// Fetch-port and byte-memory signals seen by the instruction responder.
interface inst_mem_responder_if
  import inst_mem_responder_pkg::*;
#(
  parameter int unsigned MEM_AW = MEM_AW_DEFAULT
);

  logic              ce_i;
  inst_addr_bus_t    addr_i;
  inst_bus_t         inst_o;
  logic              stall_o;
  logic              inv_i;
  logic              mem_re_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic [7:0]        mem_data_i;
  logic              mem_valid_i;

  modport slave (
    input  ce_i, addr_i, inv_i, mem_data_i, mem_valid_i,
    output inst_o, stall_o, mem_re_o, mem_addr_o
  );

  modport master (
    output ce_i, addr_i, inv_i, mem_data_i, mem_valid_i,
    input  inst_o, stall_o, mem_re_o, mem_addr_o
  );

endinterface

// File: rtl/inst_byte_assembler.sv
// Collects four little-endian bytes into the fetch buffer word and pulses
// done on the fourth accepted byte.
module inst_byte_assembler
  import inst_mem_responder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] data,
  output logic [1:0] idx,
  output inst_bus_t  word,
  output logic       done
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx  <= '0;
      word <= '0;
    end else if (en) begin
      word[8*idx +: 8] <= data;
      idx              <= idx + 2'd1;
    end
  end

  assign done = en && (idx == 2'd3);

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-fetch responder: one-word fetch buffer in front of a byte-wide,
// variable-latency memory; misses stall the core until the word is filled.
module inst_mem_responder
  import inst_mem_responder_pkg::*;
#(
  parameter int unsigned MEM_AW = MEM_AW_DEFAULT
)(
  input  logic                 clk,
  input  logic                 rst,
  inst_mem_responder_if.slave  bus
);

  fetch_state_e state, state_nxt;
  logic         buf_valid;
  buf_tag_t     buf_tag;
  inst_bus_t    buf_data;
  logic [1:0]   idx;
  logic         hit;
  logic         busy;
  logic         miss_start;
  logic         abort;
  logic         byte_en;
  logic         fill_done;
  logic         addr_lsb_unused;

  assign addr_lsb_unused = ^bus.addr_i[1:0];

  assign busy       = (state == FETCH_BUSY);
  assign hit        = bus.ce_i && buf_valid && (buf_tag == bus.addr_i[31:2]);
  assign miss_start = !busy && bus.ce_i && !hit;
  assign abort      = busy && !bus.ce_i;
  assign byte_en    = busy && bus.ce_i && bus.mem_valid_i;

  inst_byte_assembler u_asm (
    .clk  (clk),
    .rst  (rst),
    .clear(abort),
    .en   (byte_en),
    .data (bus.mem_data_i),
    .idx  (idx),
    .word (buf_data),
    .done (fill_done)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH_IDLE: if (miss_start) state_nxt = FETCH_BUSY;
      FETCH_BUSY: if (!bus.ce_i || fill_done) state_nxt = FETCH_IDLE;
      default:    state_nxt = FETCH_IDLE;
    endcase
  end

  always_comb begin
    bus.inst_o     = ZERO_WORD;
    bus.stall_o    = 1'b0;
    bus.mem_re_o   = 1'b0;
    bus.mem_addr_o = '0;
    if (!rst) begin
      if (hit) bus.inst_o = buf_data;
      bus.stall_o = bus.ce_i && !hit;
      if (busy) begin
        bus.mem_re_o   = 1'b1;
        bus.mem_addr_o = {bus.addr_i[MEM_AW-1:2], idx};
      end
    end
  end

  // A new fill overwrites the buffer lanes, so the old word stops being
  // valid as soon as the miss is taken; invalidate beats fill completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH_IDLE;
      buf_valid <= 1'b0;
      buf_tag   <= '0;
    end else begin
      state <= state_nxt;
      if (bus.inv_i)       buf_valid <= 1'b0;
      else if (fill_done)  buf_valid <= 1'b1;
      else if (miss_start) buf_valid <= 1'b0;
      if (fill_done) buf_tag <= bus.addr_i[31:2];
    end
  end

endmodule
